// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, word-write, little-endian memory between the
// instruction fetch port and the load/store data port.
//   - Round-robin grant between the two ports. Each access is sequenced through an FSM.
//   - A byte or halfword store becomes a read-modify-write pair.
//   - A misaligned, out-of-range or illegal-size access is acked with err and never reaches
//     memory.
// Ports:
//   clock, reset                      system clock; asynchronous active-high reset
//   fetch_req/addr -> ack/err/rdata   read-only fetch port, word accesses only
//   data_req/addr/we/size/wdata       load/store port; size 0=byte, 1=half, 2=word
//     -> data_ack/err/rdata
//   mem_address/data_in/read_write    memory command; memory writes on posedge while
//                                     mem_read_write=1
//   mem_data_out                      combinational read data from memory
module mem_port_arbiter #(
  parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic        fetch_err,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StRmwRd, StRmwWr, StResp} state_e;

  state_e      state_q;
  logic        last_data_q;   // 1: the data port held the most recent grant
  logic        grant_data_q;  // port owning the transaction in flight
  logic [1:0]  lane_q;        // addr[1:0] of a pending partial store
  logic        half_q;        // pending partial store is a halfword
  logic [15:0] wdata_q;       // low bits of a pending partial store

  // Request decode for the IDLE sampling edge.
  logic        grant_fetch, grant_data;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_we;
  logic [1:0]  req_span;
  logic [32:0] req_last_byte;
  logic        req_err;

  assign grant_fetch = fetch_req && (!data_req || last_data_q);
  assign grant_data  = data_req && !grant_fetch;
  assign req_addr    = grant_data ? data_addr : fetch_addr;
  assign req_size    = grant_data ? data_size : 2'd2;
  assign req_we      = grant_data && data_we;

  always_comb begin
    unique case (req_size)
      2'd0:    req_span = 2'd0;
      2'd1:    req_span = 2'd1;
      default: req_span = 2'd3;
    endcase
    // 33-bit arithmetic so the range check cannot wrap near the top of the address space.
    req_last_byte = {1'b0, req_addr} + {31'b0, req_span};
    req_err = (req_size == 2'd3)
           || (req_size == 2'd1 && req_addr[0])
           || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
           || ({1'b0, req_addr} < {1'b0, STARTING_ADDR})
           || (req_last_byte >= ({1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES}));
  end

  // Replace the addressed lane(s) of the old word with the pending store data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [1:0]  lane,
                                              input logic        half,
                                              input logic [15:0] wd);
    logic [31:0] res;
    res = old_word;
    if (half) begin
      if (lane[1]) res[31:16] = wd;
      else         res[15:0]  = wd;
    end else begin
      unique case (lane)
        2'd0: res[7:0]   = wd[7:0];
        2'd1: res[15:8]  = wd[7:0];
        2'd2: res[23:16] = wd[7:0];
        2'd3: res[31:24] = wd[7:0];
      endcase
    end
    return res;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      last_data_q    <= 1'b1;
      grant_data_q   <= 1'b0;
      lane_q         <= 2'b00;
      half_q         <= 1'b0;
      wdata_q        <= 16'h0;
      fetch_ack      <= 1'b0;
      fetch_err      <= 1'b0;
      fetch_rdata    <= 32'h0;
      data_ack       <= 1'b0;
      data_err       <= 1'b0;
      data_rdata     <= 32'h0;
      mem_address    <= 32'h0;
      mem_data_in    <= 32'h0;
      mem_read_write <= 1'b0;
    end else begin
      // Acks and writes are single-cycle pulses unless re-asserted below.
      fetch_ack      <= 1'b0;
      fetch_err      <= 1'b0;
      data_ack       <= 1'b0;
      data_err       <= 1'b0;
      mem_read_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fetch_req || data_req) begin
            grant_data_q <= grant_data;
            last_data_q  <= grant_data;
            lane_q       <= req_addr[1:0];
            half_q       <= (req_size == 2'd1);
            wdata_q      <= data_wdata[15:0];
            if (req_err) begin
              state_q   <= StResp;
              fetch_ack <= !grant_data;
              fetch_err <= !grant_data;
              data_ack  <= grant_data;
              data_err  <= grant_data;
            end else begin
              mem_address <= {req_addr[31:2], 2'b00};
              if (!req_we) begin
                state_q <= StRd;
              end else if (req_size == 2'd2) begin
                state_q        <= StWr;
                mem_data_in    <= data_wdata;
                mem_read_write <= 1'b1;
              end else begin
                state_q <= StRmwRd;
              end
            end
          end
        end
        StRd: begin
          if (grant_data_q) data_rdata  <= mem_data_out;
          else              fetch_rdata <= mem_data_out;
          fetch_ack <= !grant_data_q;
          data_ack  <= grant_data_q;
          state_q   <= StResp;
        end
        StWr, StRmwWr: begin
          fetch_ack <= !grant_data_q;
          data_ack  <= grant_data_q;
          state_q   <= StResp;
        end
        StRmwRd: begin
          // Merge happens on the read edge so the write cycle drives a registered word.
          mem_data_in    <= merge_lanes(mem_data_out, lane_q, half_q, wdata_q);
          mem_read_write <= 1'b1;
          state_q        <= StRmwWr;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
